// File: rtl/mem_pkg.sv
// Shared sizing defaults and port-select encoding for the arbitrated word RAM.
package mem_pkg;
    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_e;
endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous word RAM, one access per cycle, 1-cycle read latency.
module ram_sp
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    // Read-first: o_rdata always captures the pre-write contents of the addressed word.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end
            o_rdata <= r_mem[i_addr];
        end
    end
endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between a fetch port and a data port.
module ram_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata
);
    port_e             r_lastGrant;
    port_e             r_rdTag;
    logic              r_rdPending;
    logic [DATA_W-1:0] r_ifRdata;
    logic [DATA_W-1:0] r_dRdata;

    logic              w_grantIf;
    logic              w_grantD;
    logic              w_ramEn;
    logic              w_ramWe;
    logic [ADDR_W-1:0] w_ramAddr;
    logic [DATA_W-1:0] w_ramRdata;

    // Grants are gated by rst_n so they drop immediately when reset asserts.
    always_comb begin
        w_grantIf = 1'b0;
        w_grantD  = 1'b0;
        if (rst_n) begin
            if (if_req && d_req) begin
                if (r_lastGrant == PORT_IF) begin
                    w_grantD = 1'b1;
                end else begin
                    w_grantIf = 1'b1;
                end
            end else begin
                w_grantIf = if_req;
                w_grantD  = d_req;
            end
        end
    end

    assign if_gnt    = w_grantIf;
    assign d_gnt     = w_grantD;
    assign w_ramEn   = w_grantIf | w_grantD;
    assign w_ramWe   = w_grantD & d_we;
    assign w_ramAddr = w_grantD ? d_addr : if_addr;

    ram_sp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ramEn),
        .i_we    (w_ramWe),
        .i_addr  (w_ramAddr),
        .i_wdata (d_wdata),
        .o_rdata (w_ramRdata)
    );

    // One pending read at most; the tag routes the RAM output to its requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lastGrant <= PORT_IF;
            r_rdPending <= 1'b0;
            r_rdTag     <= PORT_IF;
        end else begin
            if (w_grantD) begin
                r_lastGrant <= PORT_D;
            end else if (w_grantIf) begin
                r_lastGrant <= PORT_IF;
            end
            r_rdPending <= w_grantIf | (w_grantD & ~d_we);
            r_rdTag     <= w_grantD ? PORT_D : PORT_IF;
        end
    end

    assign if_rvalid = r_rdPending && (r_rdTag == PORT_IF);
    assign d_rvalid  = r_rdPending && (r_rdTag == PORT_D);

    // Hold registers keep rdata stable between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ifRdata <= '0;
            r_dRdata  <= '0;
        end else begin
            if (if_rvalid) begin
                r_ifRdata <= w_ramRdata;
            end
            if (d_rvalid) begin
                r_dRdata <= w_ramRdata;
            end
        end
    end

    assign if_rdata = if_rvalid ? w_ramRdata : r_ifRdata;
    assign d_rdata  = d_rvalid  ? w_ramRdata : r_dRdata;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed, table-driven bench for ram_arbiter with hand-computed expectations.
module tb_ram_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;

    typedef struct {
        logic          ifReq;
        logic [AW-1:0] ifAddr;
        logic          dReq;
        logic          dWe;
        logic [AW-1:0] dAddr;
        logic [DW-1:0] dWdata;
        logic          expIfGnt;
        logic          expDGnt;
        logic          expIfRvalid;
        logic          expDRvalid;
        logic [DW-1:0] expIfRdata;
        logic [DW-1:0] expDRdata;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    int checks = 0;
    int errors = 0;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(
        input logic ir, input logic [AW-1:0] ia, input logic dr, input logic dw,
        input logic [AW-1:0] da, input logic [DW-1:0] dd, input logic eig, input logic edg,
        input logic eiv, input logic edv, input logic [DW-1:0] eir, input logic [DW-1:0] edr);
        vec_t v;
        v.ifReq = ir; v.ifAddr = ia; v.dReq = dr; v.dWe = dw; v.dAddr = da; v.dWdata = dd;
        v.expIfGnt = eig; v.expDGnt = edg; v.expIfRvalid = eiv; v.expDRvalid = edv;
        v.expIfRdata = eir; v.expDRdata = edr;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then check all outputs mid-cycle.
    task automatic applyStimulus(input vec_t v, input string tag);
        @(negedge clk);
        if_req  = v.ifReq;
        if_addr = v.ifAddr;
        d_req   = v.dReq;
        d_we    = v.dWe;
        d_addr  = v.dAddr;
        d_wdata = v.dWdata;
        #1;
        checkOutput({tag, " if_gnt"},    {31'b0, if_gnt},    {31'b0, v.expIfGnt});
        checkOutput({tag, " d_gnt"},     {31'b0, d_gnt},     {31'b0, v.expDGnt});
        checkOutput({tag, " if_rvalid"}, {31'b0, if_rvalid}, {31'b0, v.expIfRvalid});
        checkOutput({tag, " d_rvalid"},  {31'b0, d_rvalid},  {31'b0, v.expDRvalid});
        checkOutput({tag, " if_rdata"},  if_rdata,           v.expIfRdata);
        checkOutput({tag, " d_rdata"},   d_rdata,            v.expDRdata);
    endtask

    vec_t vecs[16];
    vec_t idle;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] ifHold;
        logic [DW-1:0] expData;
        vec_t v;

        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        idle = mkVec(0, 12'h000, 0, 0, 12'h000, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);

        // Both ports requesting during reset must see no grant and cleared outputs.
        applyStimulus(mkVec(1, 12'h010, 1, 0, 12'h020, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0), "rst");
        applyStimulus(mkVec(1, 12'h010, 1, 1, 12'h020, 32'h5, 0, 0, 0, 0, 32'h0, 32'h0), "rst2");
        @(negedge clk);
        rst_n = 1'b1;

        vecs[0]  = mkVec(0, 12'h000, 1, 1, 12'h010, 32'hDEADBEEF, 0, 1, 0, 0, 32'h0,        32'h0);
        vecs[1]  = mkVec(0, 12'h000, 1, 1, 12'hFFF, 32'hCAFEF00D, 0, 1, 0, 0, 32'h0,        32'h0);
        vecs[2]  = mkVec(0, 12'h000, 1, 1, 12'h000, 32'h11111111, 0, 1, 0, 0, 32'h0,        32'h0);
        vecs[3]  = mkVec(0, 12'h000, 1, 1, 12'h7FF, 32'h12345678, 0, 1, 0, 0, 32'h0,        32'h0);
        vecs[4]  = mkVec(0, 12'h000, 1, 0, 12'h7FF, 32'h0,        0, 1, 0, 0, 32'h0,        32'h0);
        vecs[5]  = mkVec(0, 12'h000, 0, 0, 12'h000, 32'h0,        0, 0, 0, 1, 32'h0,        32'h12345678);
        vecs[6]  = mkVec(0, 12'h000, 1, 0, 12'hFFF, 32'h0,        0, 1, 0, 0, 32'h0,        32'h12345678);
        vecs[7]  = mkVec(0, 12'h000, 0, 0, 12'h000, 32'h0,        0, 0, 0, 1, 32'h0,        32'hCAFEF00D);
        vecs[8]  = mkVec(1, 12'h010, 0, 0, 12'h000, 32'h0,        1, 0, 0, 0, 32'h0,        32'hCAFEF00D);
        vecs[9]  = mkVec(0, 12'h000, 0, 0, 12'h000, 32'h0,        0, 0, 1, 0, 32'hDEADBEEF, 32'hCAFEF00D);
        vecs[10] = mkVec(1, 12'h010, 1, 0, 12'h000, 32'h0,        0, 1, 0, 0, 32'hDEADBEEF, 32'hCAFEF00D);
        vecs[11] = mkVec(1, 12'h010, 1, 0, 12'hFFF, 32'h0,        1, 0, 0, 1, 32'hDEADBEEF, 32'h11111111);
        vecs[12] = mkVec(1, 12'h7FF, 1, 0, 12'hFFF, 32'h0,        0, 1, 1, 0, 32'hDEADBEEF, 32'h11111111);
        vecs[13] = mkVec(1, 12'h7FF, 1, 0, 12'h010, 32'h0,        1, 0, 0, 1, 32'hDEADBEEF, 32'hCAFEF00D);
        vecs[14] = mkVec(0, 12'h000, 1, 0, 12'h010, 32'h0,        0, 1, 1, 0, 32'h12345678, 32'hCAFEF00D);
        vecs[15] = mkVec(0, 12'h000, 0, 0, 12'h000, 32'h0,        0, 0, 0, 1, 32'h12345678, 32'hDEADBEEF);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // After a fresh reset the data port must win the first conflict, then alternate.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(mkVec(1, 12'h010, 1, 0, 12'h7FF, 32'h0, 0, 1, 0, 0, 32'h0,        32'h0),        "cf0");
        applyStimulus(mkVec(1, 12'h010, 1, 0, 12'h7FF, 32'h0, 1, 0, 0, 1, 32'h0,        32'h12345678), "cf1");
        applyStimulus(mkVec(1, 12'h010, 1, 0, 12'h7FF, 32'h0, 0, 1, 1, 0, 32'hDEADBEEF, 32'h12345678), "cf2");
        applyStimulus(mkVec(1, 12'h010, 1, 0, 12'h7FF, 32'h0, 1, 0, 0, 1, 32'hDEADBEEF, 32'h12345678), "cf3");
        applyStimulus(mkVec(0, 12'h000, 0, 0, 12'h000, 32'h0, 0, 0, 1, 0, 32'hDEADBEEF, 32'h12345678), "cf4");

        // Fill words 0..7, then stream fetches across them back-to-back.
        for (int i = 0; i < 8; i++) begin
            v = mkVec(0, 12'h000, 1, 1, AW'(i), 32'hA0000000 + DW'(i), 0, 1, 0, 0, 32'hDEADBEEF, 32'h12345678);
            applyStimulus(v, $sformatf("fill%0d", i));
        end
        ifHold = 32'hDEADBEEF;
        for (int i = 0; i <= 8; i++) begin
            expData = (i > 0) ? 32'hA0000000 + DW'(i - 1) : ifHold;
            v = mkVec(i < 8, AW'(i % 8), 0, 0, 12'h000, 32'h0, i < 8, 0, i > 0, 0, expData, 32'h12345678);
            applyStimulus(v, $sformatf("stream%0d", i));
        end

        // Reset right after a fetch is accepted must kill its response.
        applyStimulus(mkVec(1, 12'h003, 0, 0, 12'h000, 32'h0, 1, 0, 0, 0, 32'hA0000007, 32'h12345678), "mid0");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid if_rvalid", {31'b0, if_rvalid}, 32'h0);
        checkOutput("mid if_rdata", if_rdata, 32'h0);
        applyStimulus(idle, "midrst");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(idle, "post0");
        applyStimulus(idle, "post1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
